proc_packet_arbiter: RTL and testbench

- Shares the single Garnet processor packet interface (proc_packet_wr_*/rd_*) among NUM_REQ requesters, e.g. host driver, DMA engine, debug port.
- Arbitrates round-robin, with at most one packet issued per cycle.
- Tracks outstanding reads in an in-order ID FIFO so each proc_packet_rd_data response returns to the requester that issued the read.
- Sits between the requester logic and the Garnet top-level proc ports.

---
 rtl/proc_packet_arbiter.sv | 126 ++++++++++++
 tb/tb_proc_packet_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_packet_arbiter.sv
// rtl/proc_packet_arbiter.sv - round-robin arbiter sharing the Garnet proc packet port
module proc_packet_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 22,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            proc_wr_en,
    output logic [DATA_WIDTH/8-1:0]         proc_wr_strb,
    output logic [ADDR_WIDTH-1:0]           proc_wr_addr,
    output logic [DATA_WIDTH-1:0]           proc_wr_data,
    output logic                            proc_rd_en,
    output logic [ADDR_WIDTH-1:0]           proc_rd_addr,
    input  logic [DATA_WIDTH-1:0]           proc_rd_data,
    input  logic                            proc_rd_data_valid,
    output logic                            err_unexpected_rsp
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = DATA_WIDTH / 8;
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      grant_idx;
    logic               grant_valid;
    logic [NUM_REQ-1:0] eligible;
    logic [CW-1:0]      count;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [IW-1:0]      id_mem [MAX_OUTSTANDING];
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    int                 cand;

    assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);

    // Reads wait on a full ID FIFO; writes never do, so they are searched past blocked reads.
    always_comb begin
        eligible    = req_valid & (req_wr | {NUM_REQ{~fifo_full}});
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_valid) req_ready[grant_idx] = 1'b1;
    end

    assign push = grant_valid && !req_wr[grant_idx];
    assign pop  = proc_rd_data_valid && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr                <= '0;
            count              <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            proc_wr_en         <= 1'b0;
            proc_wr_strb       <= '0;
            proc_wr_addr       <= '0;
            proc_wr_data       <= '0;
            proc_rd_en         <= 1'b0;
            proc_rd_addr       <= '0;
            rsp_valid          <= '0;
            rsp_data           <= '0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            proc_wr_en <= 1'b0;
            proc_rd_en <= 1'b0;
            if (grant_valid) begin
                ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
                if (req_wr[grant_idx]) begin
                    proc_wr_en   <= 1'b1;
                    proc_wr_addr <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    proc_wr_data <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    proc_wr_strb <= req_strb[grant_idx*SW +: SW];
                end else begin
                    proc_rd_en   <= 1'b1;
                    proc_rd_addr <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end

            if (pop) begin
                rsp_valid <= NUM_REQ'(1) << id_mem[rd_ptr];
                rsp_data  <= proc_rd_data;
                rd_ptr    <= rd_ptr + AW'(1);
            end else begin
                rsp_valid <= '0;
            end

            if (push) wr_ptr <= wr_ptr + AW'(1);

            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);

            if (proc_rd_data_valid && fifo_empty) err_unexpected_rsp <= 1'b1;
        end
    end

    // ID storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) id_mem[wr_ptr] <= grant_idx;
    end
endmodule

// File: tb/tb_proc_packet_arbiter.sv
// tb/tb_proc_packet_arbiter.sv - directed self-checking bench for proc_packet_arbiter
module tb_proc_packet_arbiter;
    localparam int NR = 2;
    localparam int AWD = 22;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      req_wr;
    logic [NR*AWD-1:0]  req_addr;
    logic [NR*DW-1:0]   req_data;
    logic [NR*SW-1:0]   req_strb;
    logic [NR-1:0]      rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               proc_wr_en;
    logic [SW-1:0]      proc_wr_strb;
    logic [AWD-1:0]     proc_wr_addr;
    logic [DW-1:0]      proc_wr_data;
    logic               proc_rd_en;
    logic [AWD-1:0]     proc_rd_addr;
    logic [DW-1:0]      proc_rd_data;
    logic               proc_rd_data_valid;
    logic               err_unexpected_rsp;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    proc_packet_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .proc_wr_en(proc_wr_en), .proc_wr_strb(proc_wr_strb),
        .proc_wr_addr(proc_wr_addr), .proc_wr_data(proc_wr_data),
        .proc_rd_en(proc_rd_en), .proc_rd_addr(proc_rd_addr),
        .proc_rd_data(proc_rd_data), .proc_rd_data_valid(proc_rd_data_valid),
        .err_unexpected_rsp(err_unexpected_rsp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AWD-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_wr[i] = wr;
        req_addr[i*AWD +: AWD] = a;
        req_data[i*DW +: DW] = d;
        req_strb[i*SW +: SW] = s;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, rsp_data, 64'd0);
        chk({tag, "_wr_en"}, 64'(proc_wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(proc_wr_addr), 64'd0);
        chk({tag, "_wr_data"}, proc_wr_data, 64'd0);
        chk({tag, "_wr_strb"}, 64'(proc_wr_strb), 64'd0);
        chk({tag, "_rd_en"}, 64'(proc_rd_en), 64'd0);
        chk({tag, "_rd_addr"}, 64'(proc_rd_addr), 64'd0);
        chk({tag, "_err"}, 64'(err_unexpected_rsp), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0;
        req_wr = '0;
        req_addr = '0;
        req_data = '0;
        req_strb = '0;
        proc_rd_data = '0;
        proc_rd_data_valid = 1'b0;
        cyc();
        cyc();
        chk_all_zero("reset");
        chk("reset_ready", 64'(req_ready), 64'd0);
        reset_n = 1'b1;

        // single write from requester 0
        set_req(0, 1'b1, 22'h00100, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        req_valid = 2'b01;
        #1 chk("wr1_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid = 2'b00;
        chk("wr1_wr_en", 64'(proc_wr_en), 64'd1);
        chk("wr1_addr", 64'(proc_wr_addr), 64'h00100);
        chk("wr1_data", proc_wr_data, 64'hDEADBEEF_CAFEF00D);
        chk("wr1_strb", 64'(proc_wr_strb), 64'hFF);
        chk("wr1_rd_en", 64'(proc_rd_en), 64'd0);
        cyc();
        chk("wr1_idle", 64'(proc_wr_en), 64'd0);

        // round-robin: pointer sits at 1 after the write from requester 0
        set_req(0, 1'b1, 22'h0AAA, 64'h0A, 8'h0F);
        set_req(1, 1'b1, 22'h0BBB, 64'h0B, 8'hF0);
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            #1 chk("rr_ready", 64'(req_ready), (i % 2 == 0) ? 64'h2 : 64'h1);
            cyc();
            chk("rr_wr_en", 64'(proc_wr_en), 64'd1);
            chk("rr_addr", 64'(proc_wr_addr), (i % 2 == 0) ? 64'h0BBB : 64'h0AAA);
        end
        req_valid = 2'b00;

        // read routing: requester 1 then requester 0
        set_req(1, 1'b0, 22'h200, 64'h0, 8'h0);
        req_valid = 2'b10;
        #1 chk("rd_r1_ready", 64'(req_ready), 64'h2);
        cyc();
        chk("rd_r1_en", 64'(proc_rd_en), 64'd1);
        chk("rd_r1_addr", 64'(proc_rd_addr), 64'h200);
        chk("rd_r1_wr_en", 64'(proc_wr_en), 64'd0);
        set_req(0, 1'b0, 22'h300, 64'h0, 8'h0);
        req_valid = 2'b01;
        #1 chk("rd_r0_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid = 2'b00;
        chk("rd_r0_en", 64'(proc_rd_en), 64'd1);
        chk("rd_r0_addr", 64'(proc_rd_addr), 64'h300);
        cyc();
        chk("rd_wait_rsp", 64'(rsp_valid), 64'd0);
        proc_rd_data = 64'h11;
        proc_rd_data_valid = 1'b1;
        cyc();
        chk("rsp1_valid", 64'(rsp_valid), 64'h2);
        chk("rsp1_data", rsp_data, 64'h11);
        proc_rd_data = 64'h22;
        cyc();
        proc_rd_data_valid = 1'b0;
        chk("rsp2_valid", 64'(rsp_valid), 64'h1);
        chk("rsp2_data", rsp_data, 64'h22);
        cyc();
        chk("rsp_idle", 64'(rsp_valid), 64'd0);
        chk("rsp_hold", rsp_data, 64'h22);
        chk("rsp_err", 64'(err_unexpected_rsp), 64'd0);

        // fill the FIFO with four reads from requester 1
        req_valid = 2'b10;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 1'b0, 22'(32'h400 + i), 64'h0, 8'h0);
            #1 chk("fill_ready", 64'(req_ready), 64'h2);
            cyc();
            chk("fill_rd_addr", 64'(proc_rd_addr), 64'(32'h400 + i));
        end
        // pointer at 0, but the read from requester 0 is blocked by the full FIFO
        set_req(0, 1'b0, 22'h500, 64'h0, 8'h0);
        set_req(1, 1'b1, 22'h600, 64'h66, 8'h3C);
        req_valid = 2'b11;
        #1 chk("full_ready", 64'(req_ready), 64'h2);
        cyc();
        req_valid = 2'b01;
        chk("full_wr_en", 64'(proc_wr_en), 64'd1);
        chk("full_wr_addr", 64'(proc_wr_addr), 64'h600);
        chk("full_rd_en", 64'(proc_rd_en), 64'd0);
        proc_rd_data = 64'h33;
        proc_rd_data_valid = 1'b1;
        #1 chk("full_blocked", 64'(req_ready), 64'd0);
        cyc();
        proc_rd_data_valid = 1'b0;
        chk("full_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("full_rsp_data", rsp_data, 64'h33);
        #1 chk("unblock_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid = 2'b00;
        chk("unblock_rd_en", 64'(proc_rd_en), 64'd1);
        chk("unblock_rd_addr", 64'(proc_rd_addr), 64'h500);
        // drain: three from requester 1, then requester 0
        for (int i = 0; i < 4; i++) begin
            proc_rd_data = 64'(32'h40 + i);
            proc_rd_data_valid = 1'b1;
            cyc();
            chk("drain_valid", 64'(rsp_valid), (i < 3) ? 64'h2 : 64'h1);
            chk("drain_data", rsp_data, 64'(32'h40 + i));
        end
        proc_rd_data_valid = 1'b0;
        cyc();
        chk("drain_idle", 64'(rsp_valid), 64'd0);
        chk("drain_err", 64'(err_unexpected_rsp), 64'd0);

        // unexpected response with nothing outstanding
        proc_rd_data = 64'h99;
        proc_rd_data_valid = 1'b1;
        cyc();
        proc_rd_data_valid = 1'b0;
        chk("unexp_valid", 64'(rsp_valid), 64'd0);
        chk("unexp_err", 64'(err_unexpected_rsp), 64'd1);
        chk("unexp_hold", rsp_data, 64'h43);
        cyc();
        cyc();
        chk("unexp_sticky", 64'(err_unexpected_rsp), 64'd1);

        // two reads outstanding, then reset (pointer at 1 after last grant to 0)
        set_req(0, 1'b0, 22'h700, 64'h0, 8'h0);
        set_req(1, 1'b0, 22'h710, 64'h0, 8'h0);
        req_valid = 2'b11;
        #1 chk("mr_ready_a", 64'(req_ready), 64'h2);
        cyc();
        #1 chk("mr_ready_b", 64'(req_ready), 64'h1);
        cyc();
        req_valid = 2'b00;
        chk("mr_rd_addr", 64'(proc_rd_addr), 64'h700);
        reset_n = 1'b0;
        cyc();
        chk_all_zero("midrst");
        reset_n = 1'b1;
        proc_rd_data = 64'h55;
        proc_rd_data_valid = 1'b1;
        cyc();
        chk("stale1_valid", 64'(rsp_valid), 64'd0);
        chk("stale1_err", 64'(err_unexpected_rsp), 64'd1);
        proc_rd_data = 64'h66;
        cyc();
        proc_rd_data_valid = 1'b0;
        chk("stale2_valid", 64'(rsp_valid), 64'd0);
        chk("stale2_data", rsp_data, 64'd0);
        // pointer back at 0 after reset
        set_req(0, 1'b1, 22'h800, 64'h8, 8'h01);
        set_req(1, 1'b1, 22'h810, 64'h9, 8'h02);
        req_valid = 2'b11;
        #1 chk("rst_ptr_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid = 2'b00;
        chk("rst_ptr_addr", 64'(proc_wr_addr), 64'h800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
